// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and the matching receiver.
//   PAR_*              parity mode codes for the PARITY parameter
//   tx_state_t         transmitter FSM state encoding
//   calc_baud_cnt_max  clock cycles per line bit (integer division)
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  function automatic int calc_baud_cnt_max(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: per-bit cycle counter for the UART.
//   sys_clk, sys_rst_n  clock and asynchronous active-low reset
//   en                  count while high; counter is cleared while low
//   bit_end             high on the last cycle of each bit (count BAUD_CNT_MAX-1)
module uart_baud_gen #(
  parameter int BAUD_CNT_MAX = 5208
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic en,
  output logic bit_end
);

  localparam int CW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (!en || r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bit_end = en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with elaboration-time frame format.
//   sys_clk, sys_rst_n  clock and asynchronous active-low reset
//   pi_data/pi_valid    character input, transferred when pi_valid && pi_ready
//   pi_ready            can accept (idle, or last cycle of the last stop bit)
//   tx                  registered serial line, idle high, LSB first
//   tx_busy             frame in progress
//   tx_done             one-cycle pulse on the last cycle of the last stop bit
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int UART_BPS  = 9600,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [DATA_BITS-1:0] pi_data,
  input  logic                 pi_valid,
  output logic                 pi_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_CNT_MAX = calc_baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..8");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (BAUD_CNT_MAX < 2) begin : g_bad_baud
    $error("uart_tx_cfg: CLK_FREQ / UART_BPS must be at least 2");
  end

  tx_state_t            r_state;
  tx_state_t            w_state_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [3:0]           r_bit_cnt;
  logic                 r_par;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 w_bit_end;
  logic                 w_last_stop;
  logic                 w_accept;
  logic                 w_par_bit;

  uart_baud_gen #(
    .BAUD_CNT_MAX(BAUD_CNT_MAX)
  ) u_baud (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (r_state != ST_IDLE),
    .bit_end  (w_bit_end)
  );

  // Ready/done depend on registered state only, so no input-to-ready path exists.
  assign w_last_stop = (r_state == ST_STOP) && w_bit_end && (r_bit_cnt == LAST_STOP);
  assign pi_ready    = (r_state == ST_IDLE) || w_last_stop;
  assign tx_done     = w_last_stop;
  assign tx_busy     = (r_state != ST_IDLE);
  assign tx          = r_tx;
  assign w_accept    = pi_valid && pi_ready;
  assign w_par_bit   = (PARITY == PAR_ODD) ? ~r_par : r_par;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_START;
      ST_START:  if (w_bit_end) w_state_nxt = ST_DATA;
      ST_DATA:   if (w_bit_end && r_bit_cnt == LAST_DATA)
                   w_state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_bit_end) w_state_nxt = ST_STOP;
      ST_STOP:   if (w_last_stop) w_state_nxt = w_accept ? ST_START : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_shift_nxt = r_shift;
    if (w_accept) begin
      w_shift_nxt = pi_data;
    end else if (r_state == ST_DATA && w_bit_end) begin
      w_shift_nxt = r_shift >> 1;
    end
  end

  // tx is registered from the next state so the start bit appears one cycle
  // after the accept edge; in DATA the next LSB already reflects any shift.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
      ST_PARITY: w_tx_nxt = w_par_bit;
      default:   w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_tx      <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      if (w_accept) begin
        r_par <= ^pi_data;
      end
      // Bit index restarts on every state change, counts bit ends otherwise.
      if (w_state_nxt != r_state) begin
        r_bit_cnt <= '0;
      end else if (w_bit_end) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: bench for uart_tx_cfg with four frame formats at 10 cycles/bit:
//   inst0 8N1, inst1 8E1, inst2 8O1, inst3 5N2.
module tb_uart_tx_cfg;

  localparam int NI  = 4;
  localparam int BIT = 10;

  function automatic int db_of(input int i);
    return (i == 3) ? 5 : 8;
  endfunction
  function automatic int par_of(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction
  function automatic int sb_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int last_of(input int i);
    return (1 + db_of(i) + ((par_of(i) != 0) ? 1 : 0) + sb_of(i)) * BIT - 1;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pdata  [NI];
  logic       pvalid [NI];
  logic       tx_w   [NI];
  logic       rdy_w  [NI];
  logic       busy_w [NI];
  logic       done_w [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DB = db_of(g);
    uart_tx_cfg #(
      .UART_BPS (100_000),
      .CLK_FREQ (1_000_000),
      .DATA_BITS(DB),
      .PARITY   (par_of(g)),
      .STOP_BITS(sb_of(g))
    ) u_dut (
      .sys_clk  (clk),
      .sys_rst_n(rst_n),
      .pi_data  (pdata[g][DB-1:0]),
      .pi_valid (pvalid[g]),
      .pi_ready (rdy_w[g]),
      .tx       (tx_w[g]),
      .tx_busy  (busy_w[g]),
      .tx_done  (done_w[g])
    );
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: a frame is a list of line bits, each held BIT cycles.
  bit        m_busy [NI];
  int        m_pos  [NI];
  bit [11:0] m_bits [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_busy[i] = 1'b0;
      m_pos[i]  = 0;
      m_bits[i] = '1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_busy[i] = 1'b0;
        m_pos[i]  = 0;
      end else if (pvalid[i] && (!m_busy[i] || m_pos[i] == last_of(i))) begin
        bit p;
        p = 1'b0;
        m_bits[i] = '1;
        m_bits[i][0] = 1'b0;
        for (int k = 0; k < db_of(i); k++) begin
          m_bits[i][1+k] = pdata[i][k];
          p ^= pdata[i][k];
        end
        if (par_of(i) == 2) m_bits[i][1+db_of(i)] = p;
        else if (par_of(i) == 1) m_bits[i][1+db_of(i)] = ~p;
        m_busy[i] = 1'b1;
        m_pos[i]  = 0;
      end else if (m_busy[i]) begin
        if (m_pos[i] == last_of(i)) m_busy[i] = 1'b0;
        else m_pos[i] = m_pos[i] + 1;
      end
    end
  end

  // Hand-computed expectations: absolute cycle, instance, signal (0 tx,1 ready,2 busy,3 done).
  int    l_cyc  [128];
  int    l_inst [128];
  int    l_sig  [128];
  logic  l_val  [128];
  string l_nm   [128];
  int    n_lit = 0;

  task automatic add_lit(input int c, input int inst, input int sig, input logic v, input string nm);
    l_cyc[n_lit] = c; l_inst[n_lit] = inst; l_sig[n_lit] = sig;
    l_val[n_lit] = v; l_nm[n_lit] = nm;
    n_lit++;
  endtask

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int inst, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc %0d actual %b required %b", nm, inst, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic e_tx, e_rdy, e_done, act;
    for (int i = 0; i < NI; i++) begin
      e_tx   = m_busy[i] ? m_bits[i][m_pos[i] / BIT] : 1'b1;
      e_rdy  = !m_busy[i] || (m_pos[i] == last_of(i));
      e_done = m_busy[i] && (m_pos[i] == last_of(i));
      check("model_tx",    i, tx_w[i],   e_tx);
      check("model_ready", i, rdy_w[i],  e_rdy);
      check("model_busy",  i, busy_w[i], m_busy[i]);
      check("model_done",  i, done_w[i], e_done);
    end
    for (int k = 0; k < n_lit; k++) begin
      if (l_cyc[k] == cyc) begin
        case (l_sig[k])
          0:       act = tx_w[l_inst[k]];
          1:       act = rdy_w[l_inst[k]];
          2:       act = busy_w[l_inst[k]];
          default: act = done_w[l_inst[k]];
        endcase
        check(l_nm[k], l_inst[k], act, l_val[k]);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge with the instance idle; returns the accept cycle.
  task automatic send(input int i, input logic [7:0] d, output int t);
    pdata[i] = d;
    pvalid[i] = 1'b1;
    t = cyc;
    @(negedge clk);
    pvalid[i] = 1'b0;
  endtask

  initial begin
    int t, t2, guard;
    for (int i = 0; i < NI; i++) begin
      pdata[i]  = 8'h00;
      pvalid[i] = 1'b0;
    end
    @(negedge clk);
    add_lit(cyc + 1, 0, 0, 1'b1, "rst_tx");
    add_lit(cyc + 1, 0, 1, 1'b1, "rst_ready");
    add_lit(cyc + 1, 0, 2, 1'b0, "rst_busy");
    add_lit(cyc + 1, 0, 3, 1'b0, "rst_done");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0x55
    send(0, 8'h55, t);
    add_lit(t + 1,   0, 0, 1'b0, "n81_start_first");
    add_lit(t + 10,  0, 0, 1'b0, "n81_start_last");
    add_lit(t + 11,  0, 0, 1'b1, "n81_d0");
    add_lit(t + 21,  0, 0, 1'b0, "n81_d1");
    add_lit(t + 31,  0, 0, 1'b1, "n81_d2");
    add_lit(t + 90,  0, 0, 1'b0, "n81_d7");
    add_lit(t + 91,  0, 0, 1'b1, "n81_stop");
    add_lit(t + 1,   0, 1, 1'b0, "n81_ready_low_first");
    add_lit(t + 99,  0, 1, 1'b0, "n81_ready_low_last");
    add_lit(t + 100, 0, 1, 1'b1, "n81_ready_done");
    add_lit(t + 99,  0, 3, 1'b0, "n81_done_early");
    add_lit(t + 100, 0, 3, 1'b1, "n81_done");
    add_lit(t + 101, 0, 2, 1'b0, "n81_idle");
    wait_until(t + 105);

    // 0x07 with even (inst1) and odd (inst2) parity together
    pdata[1] = 8'h07; pdata[2] = 8'h07;
    pvalid[1] = 1'b1; pvalid[2] = 1'b1;
    t = cyc;
    @(negedge clk);
    pvalid[1] = 1'b0; pvalid[2] = 1'b0;
    add_lit(t + 35,  1, 0, 1'b1, "even_d2");
    add_lit(t + 45,  1, 0, 1'b0, "even_d3");
    add_lit(t + 95,  1, 0, 1'b1, "even_parity");
    add_lit(t + 95,  2, 0, 1'b0, "odd_parity");
    add_lit(t + 105, 1, 0, 1'b1, "even_stop");
    add_lit(t + 109, 1, 3, 1'b0, "even_done_early");
    add_lit(t + 110, 1, 3, 1'b1, "even_done");
    add_lit(t + 110, 2, 3, 1'b1, "odd_done");
    wait_until(t + 115);

    // 5N2 0x1F
    send(3, 8'h1F, t);
    add_lit(t + 5,  3, 0, 1'b0, "n52_start");
    add_lit(t + 15, 3, 0, 1'b1, "n52_d0");
    add_lit(t + 55, 3, 0, 1'b1, "n52_d4");
    add_lit(t + 65, 3, 0, 1'b1, "n52_stop1");
    add_lit(t + 75, 3, 0, 1'b1, "n52_stop2");
    add_lit(t + 79, 3, 3, 1'b0, "n52_done_early");
    add_lit(t + 80, 3, 3, 1'b1, "n52_done");
    add_lit(t + 81, 3, 2, 1'b0, "n52_idle");
    wait_until(t + 85);

    // Back-to-back 0xA5 then 0x3C on inst0
    pdata[0] = 8'hA5;
    pvalid[0] = 1'b1;
    t = cyc;
    @(negedge clk);
    pdata[0] = 8'h3C;
    guard = 0;
    while (!rdy_w[0] && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    pvalid[0] = 1'b0;
    add_lit(t + 11,  0, 0, 1'b1, "b2b_a5_d0");
    add_lit(t + 21,  0, 0, 1'b0, "b2b_a5_d1");
    add_lit(t + 100, 0, 3, 1'b1, "b2b_done1");
    add_lit(t + 100, 0, 2, 1'b1, "b2b_busy_seam");
    add_lit(t + 101, 0, 0, 1'b0, "b2b_start2");
    add_lit(t + 101, 0, 2, 1'b1, "b2b_busy2");
    add_lit(t + 111, 0, 0, 1'b0, "b2b_3c_d0");
    add_lit(t + 131, 0, 0, 1'b1, "b2b_3c_d2");
    add_lit(t + 200, 0, 3, 1'b1, "b2b_done2");
    add_lit(t + 201, 0, 2, 1'b0, "b2b_idle");
    wait_until(t + 205);

    // Latching and ignored mid-frame valid on inst0
    send(0, 8'h00, t);
    pdata[0] = 8'hFF;
    wait_until(t + 40);
    pdata[0] = 8'hAA;
    pvalid[0] = 1'b1;
    @(negedge clk);
    pvalid[0] = 1'b0;
    add_lit(t + 15,  0, 0, 1'b0, "latch_d0");
    add_lit(t + 45,  0, 0, 1'b0, "latch_d3");
    add_lit(t + 85,  0, 0, 1'b0, "latch_d7");
    add_lit(t + 100, 0, 3, 1'b1, "latch_done");
    add_lit(t + 101, 0, 2, 1'b0, "ignore_idle");
    add_lit(t + 102, 0, 0, 1'b1, "ignore_tx_high");
    wait_until(t + 105);

    // Reset during data bit 3 of 0x55, then a clean frame
    send(0, 8'h55, t);
    add_lit(t + 44, 0, 0, 1'b0, "prerst_d3");
    add_lit(t + 45, 0, 0, 1'b1, "midrst_tx");
    add_lit(t + 45, 0, 2, 1'b0, "midrst_busy");
    add_lit(t + 45, 0, 1, 1'b1, "midrst_ready");
    add_lit(t + 45, 0, 3, 1'b0, "midrst_done");
    wait_until(t + 44);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 8'h3C, t2);
    add_lit(t2 + 1,   0, 0, 1'b0, "post_start");
    add_lit(t2 + 21,  0, 0, 1'b0, "post_d1");
    add_lit(t2 + 31,  0, 0, 1'b1, "post_d2");
    add_lit(t2 + 100, 0, 3, 1'b1, "post_done");
    wait_until(t2 + 110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
